// File: rtl/ws2812_driver_if.sv
// rtl/ws2812_driver_if.sv - colour/enable inputs and serial status outputs of the WS2812 driver
interface ws2812_driver_if;
  logic       enable;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       dout;
  logic       busy;
  logic       frame_done;

  // Colour source / frame requester side
  modport master (
    output enable, red, green, blue,
    input  dout, busy, frame_done
  );

  // Driver side
  modport slave (
    input  enable, red, green, blue,
    output dout, busy, frame_done
  );
endinterface

// File: rtl/ws2812_driver.sv
// rtl/ws2812_driver.sv - WS2812 serial LED driver, option macro WS2812_UPDATE_ON_CHANGE_EN (send only on colour change)
module ws2812_driver #(
  parameter int NUM_LEDS = 1,
  parameter int T0H_CYC  = 4,
  parameter int T1H_CYC  = 8,
  parameter int BIT_CYC  = 12,
  parameter int RST_CYC  = 600
) (
  input  logic           clk,
  input  logic           reset,
  ws2812_driver_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BIT, S_GAP} state_t;

  localparam int CYC_W = $clog2(BIT_CYC + 1);
  localparam int LED_W = $clog2(NUM_LEDS + 1);
  localparam int GAP_W = $clog2(RST_CYC + 1);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYC - 1);
  localparam logic [CYC_W-1:0] T0H_LEN  = CYC_W'(T0H_CYC);
  localparam logic [CYC_W-1:0] T1H_LEN  = CYC_W'(T1H_CYC);
  localparam logic [LED_W-1:0] LED_LAST = LED_W'(NUM_LEDS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RST_CYC - 1);

  state_t           state_q, state_d;
  logic [23:0]      shreg_q, shreg_d;
  logic [23:0]      color_q, color_d;
  logic [4:0]       bit_q, bit_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             dout_q, dout_d;
  logic             frame_done_q, frame_done_d;

  logic [23:0]      live_color;
  logic             start;
  logic [CYC_W-1:0] high_len;

  // Wire order on the line is G, R, B, so that is the latch order too
  assign live_color = {bus.green, bus.red, bus.blue};
  assign high_len   = shreg_q[23] ? T1H_LEN : T0H_LEN;

`ifdef WS2812_UPDATE_ON_CHANGE_EN
  logic sent_q, sent_d;

  // Only re-send when nothing has gone out yet or the colour moved
  assign start = bus.enable && (!sent_q || (live_color != color_q));

  // Remember that at least one frame was latched since reset
  always_comb begin
    sent_d = sent_q;
    if (state_q == S_IDLE && start) begin
      sent_d = 1'b1;
    end
  end

  // Frame-sent flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sent_q <= 1'b0;
    end else begin
      sent_q <= sent_d;
    end
  end
`else
  assign start = bus.enable;
`endif

  // Next-state, counters, shift register and output levels
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    color_d      = color_q;
    bit_d        = bit_q;
    cyc_d        = cyc_q;
    led_d        = led_q;
    gap_d        = gap_q;
    dout_d       = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          color_d = live_color;
          shreg_d = live_color;
          bit_d   = '0;
          cyc_d   = '0;
          led_d   = '0;
          gap_d   = '0;
          state_d = S_BIT;
        end
      end
      S_BIT: begin
        // High phase first, then low for the rest of the bit slot
        dout_d = (cyc_q < high_len);
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (bit_q == 5'd23) begin
            bit_d = '0;
            if (led_q == LED_LAST) begin
              gap_d   = '0;
              state_d = S_GAP;
            end else begin
              // Every LED gets the colour latched at frame start, never the live inputs
              led_d   = led_q + 1'b1;
              shreg_d = color_q;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = {shreg_q[22:0], 1'b0};
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d        = '0;
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any frame at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      color_q      <= '0;
      bit_q        <= '0;
      cyc_q        <= '0;
      led_q        <= '0;
      gap_q        <= '0;
      dout_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      color_q      <= color_d;
      bit_q        <= bit_d;
      cyc_q        <= cyc_d;
      led_q        <= led_d;
      gap_q        <= gap_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_driver.sv
// tb/tb_ws2812_driver.sv - self-checking bench for ws2812_driver (2 LEDs, short timing)
module tb_ws2812_driver;

  localparam int NLED = 2;
  localparam int BITC = 6;
  localparam int RSTC = 10;
  localparam int FRAME_LEN = NLED * 24 * BITC + RSTC;   // 298
  localparam int NSAMP = FRAME_LEN + 1;                 // one extra sample past frame_done

`ifdef WS2812_UPDATE_ON_CHANGE_EN
  localparam logic EXP_RESTART = 1'b0;
`else
  localparam logic EXP_RESTART = 1'b1;
`endif

  logic clk = 1'b0;
  logic reset;

  ws2812_driver_if bus ();

  ws2812_driver #(
    .NUM_LEDS(2),
    .T0H_CYC (2),
    .T1H_CYC (4),
    .BIT_CYC (6),
    .RST_CYC (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic s_dout [0:NSAMP-1];
  logic s_busy [0:NSAMP-1];
  logic s_done [0:NSAMP-1];

  typedef struct {
    string      name;
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
    logic [23:0] exp_word;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for the first dout high, then record one frame plus one cycle
  task automatic capture(output bit got);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.dout) got = 1'b1;
    end
    s_dout[0] = bus.dout;
    s_busy[0] = bus.busy;
    s_done[0] = bus.frame_done;
    for (int i = 1; i < NSAMP; i++) begin
      @(negedge clk);
      s_dout[i] = bus.dout;
      s_busy[i] = bus.busy;
      s_done[i] = bus.frame_done;
    end
  endtask

  // Decode one LED's 24 bits from the recorded line and judge every bit's waveform
  task automatic decode_led(input int led, output logic [23:0] w, output bit shape_ok);
    int base;
    int hi;
    shape_ok = 1'b1;
    w = '0;
    for (int k = 0; k < 24; k++) begin
      base = (led * 24 + k) * BITC;
      hi = 0;
      for (int j = 0; j < BITC; j++) if (s_dout[base + j]) hi++;
      if (hi != 2 && hi != 4) shape_ok = 1'b0;
      for (int j = 0; j < BITC; j++) if (s_dout[base + j] !== (j < hi)) shape_ok = 1'b0;
      w = {w[22:0], (hi == 4)};
    end
  endtask

  task automatic check_frame(input string name, input bit got, input logic [23:0] exp_word);
    logic [23:0] w0, w1;
    bit ok0, ok1, gap_ok;
    int done_cnt, done_idx;
    check({name, "_start"}, got, 1'b1);
    decode_led(0, w0, ok0);
    decode_led(1, w1, ok1);
    check({name, "_led0"}, w0, exp_word);
    check({name, "_led1"}, w1, exp_word);
    check({name, "_bitshape"}, {ok0, ok1}, 2'b11);
    gap_ok = 1'b1;
    for (int i = NLED * 24 * BITC; i < FRAME_LEN; i++) if (s_dout[i] !== 1'b0) gap_ok = 1'b0;
    check({name, "_gap_low"}, gap_ok, 1'b1);
    done_cnt = 0;
    done_idx = -1;
    for (int i = 0; i < NSAMP; i++) begin
      if (s_done[i]) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
    end
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_frame_len"}, done_idx + 1, FRAME_LEN);
    check({name, "_busy_gap_end"}, {s_busy[FRAME_LEN-2], s_busy[FRAME_LEN-1]}, 2'b10);
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 700 && bus.busy; k++) @(negedge clk);
    check(name, bus.busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit got;
    int cnt;

    vecs[0] = '{"v_g80_r00_b01", 8'h80, 8'h00, 8'h01, 24'h800001};
    vecs[1] = '{"v_all_ones",    8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF};
    vecs[2] = '{"v_all_zero",    8'h00, 8'h00, 8'h00, 24'h000000};
    vecs[3] = '{"v_a5_3c_0f",    8'hA5, 8'h3C, 8'h0F, 24'hA53C0F};

    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.red    = 8'h00;
    bus.green  = 8'h00;
    bus.blue   = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_dout", bus.dout, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_frame_done", bus.frame_done, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_without_enable", bus.busy, 1'b0);

    // Single frames: enable held for one cycle only, so it falls during LED 0
    for (int v = 0; v < 4; v++) begin
      bus.green  = vecs[v].g;
      bus.red    = vecs[v].r;
      bus.blue   = vecs[v].b;
      bus.enable = 1'b1;
      @(negedge clk);
      bus.enable = 1'b0;
      capture(got);
      check_frame(vecs[v].name, got, vecs[v].exp_word);
      check({vecs[v].name, "_no_restart"}, {s_busy[NSAMP-1], s_dout[NSAMP-1]}, 2'b00);
      cnt = 0;
      repeat (10) begin
        @(negedge clk);
        if (bus.busy || bus.dout || bus.frame_done) cnt++;
      end
      check({vecs[v].name, "_stays_idle"}, cnt, 0);
    end

    // Input change mid-frame is ignored until the next latch; frames run back to back
    bus.green  = 8'h80;
    bus.red    = 8'h00;
    bus.blue   = 8'h01;
    bus.enable = 1'b1;
    fork
      capture(got);
      begin
        repeat (60) @(negedge clk);
        bus.red = 8'hFF;
      end
    join
    check_frame("midchg_f1", got, 24'h800001);
    check("midchg_one_idle_then_restart", s_busy[NSAMP-1], 1'b1);
    capture(got);
    check_frame("midchg_f2", got, 24'h80FF01);
    check("const_inputs_restart", s_busy[NSAMP-1], EXP_RESTART);
    bus.enable = 1'b0;
    wait_idle("midchg_idle");

`ifdef WS2812_UPDATE_ON_CHANGE_EN
    // Constant colour: one frame only; a colour change earns exactly one more
    bus.green  = 8'h12;
    bus.red    = 8'h34;
    bus.blue   = 8'h56;
    bus.enable = 1'b1;
    capture(got);
    check_frame("onchg_f1", got, 24'h123456);
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.busy) cnt++;
    end
    check("onchg_hold_idle", cnt, 0);
    bus.blue = 8'h57;
    capture(got);
    check_frame("onchg_f2", got, 24'h123457);
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.busy) cnt++;
    end
    check("onchg_hold_idle2", cnt, 0);
    bus.enable = 1'b0;
`endif

    // Reset during bit 10 (R5 of 0xFF, high phase) aborts immediately, no frame_done
    bus.green  = 8'h80;
    bus.red    = 8'hFF;
    bus.blue   = 8'h01;
    bus.enable = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.dout) got = 1'b1;
    end
    check("rstmid_start", got, 1'b1);
    repeat (60) @(negedge clk);
    check("rstmid_pre_dout_high", {bus.busy, bus.dout}, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    check("rstmid_async_dout", bus.dout, 1'b0);
    check("rstmid_async_busy", bus.busy, 1'b0);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.frame_done || bus.busy) cnt++;
    end
    check("rstmid_no_done", cnt, 0);
    reset = 1'b0;
    capture(got);
    check_frame("rstmid_restart", got, 24'h80FF01);
    bus.enable = 1'b0;
    wait_idle("final_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
